// File: rtl/axi_rd_arbiter.sv
// Purpose : shares one AXI4 read master (AR + R) between NUM_REQ requesters.
//           Round-robin AR arbitration, ARID = requester index, R beats routed by RID,
//           per-requester outstanding-burst limit, sticky protocol-error flags.
// Latency : AR: 1 cycle from s-side handshake to m_axi_arvalid (one AR per 2 cycles max).
//           R : combinational pass-through, zero latency.
// Backpr. : AR side is a single holding register; no s_arready while it is full.
//           R side passes s_rready[rid] straight to m_axi_rready; unknown RIDs are
//           always accepted and dropped.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_arvalid/s_arready         per-requester AR handshake
//   s_araddr/s_arlen            packed per-requester AR address / length (slice i = requester i)
//   s_rvalid/s_rready           per-requester R handshake
//   s_rdata/s_rresp/s_rlast     shared R payload, qualified by s_rvalid
//   m_axi_ar*                   master AR channel (arid = requester index)
//   m_axi_r*                    master R channel
//   outstanding                 packed per-requester in-flight burst counts (4 bits each)
//   err_flags                   sticky: bit0 RID out of range, bit1 RLAST with zero outstanding

module axi_rd_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,

    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,

    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [ID_WIDTH-1:0]           m_axi_arid,

    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,

    output logic [NUM_REQ*4-1:0]          outstanding,
    output logic [1:0]                    err_flags
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [3:0]       MAX_CNT  = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ar_state_t;

    ar_state_t              state;
    ar_state_t              state_nxt;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       winner;
    logic                   any_eligible;
    logic                   capture;
    logic [NUM_REQ-1:0]     eligible;

    logic [ADDR_WIDTH-1:0]  cap_addr;
    logic [7:0]             cap_len;

    logic [3:0]             cnt [NUM_REQ];
    logic [NUM_REQ-1:0]     cnt_inc;
    logic [NUM_REQ-1:0]     cnt_dec;
    logic [NUM_REQ-1:0]     underflow;

    logic                   rid_hit;
    logic                   r_last_hs;
    logic [1:0]             err_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // A requester that already has MAX_OUTSTANDING bursts in flight is
    // invisible to the arbiter, so the pointer search simply skips it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] < MAX_CNT);
        end
    end

    // First eligible index at or after rr_ptr, wrapping. Offset k walks the
    // rotation; the inner loop keeps every index into eligible[] constant.
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_eligible && eligible[j] &&
                    (((int'(rr_ptr) + k) % NUM_REQ) == j)) begin
                    any_eligible = 1'b1;
                    winner       = PTR_W'(j);
                end
            end
        end
    end

    // Payload mux for the winning requester.
    always_comb begin
        cap_addr = '0;
        cap_len  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == PTR_W'(j)) begin
                cap_addr = s_araddr[j*ADDR_WIDTH +: ADDR_WIDTH];
                cap_len  = s_arlen[j*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // AR holding register FSM
    // ------------------------------------------------------------------

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill and drain never share a cycle: FULL only drains, EMPTY only fills.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        s_arready = '0;
        case (state)
            EMPTY: begin
                if (any_eligible) begin
                    capture   = 1'b1;
                    state_nxt = FULL;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (winner == PTR_W'(j)) begin
                            s_arready[j] = 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                if (m_axi_arready) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    assign m_axi_arvalid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            m_axi_arid   <= '0;
            rr_ptr       <= '0;
        end else if (capture) begin
            m_axi_araddr <= cap_addr;
            m_axi_arlen  <= cap_len;
            m_axi_arid   <= ID_WIDTH'(winner);
            rr_ptr       <= (winner == LAST_IDX) ? '0 : PTR_W'(winner + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------

    // Unknown RIDs are sunk (rready = 1) so a stray beat cannot wedge the bus.
    always_comb begin
        s_rvalid     = '0;
        m_axi_rready = 1'b1;
        rid_hit      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_axi_rid == ID_WIDTH'(i)) begin
                rid_hit      = 1'b1;
                s_rvalid[i]  = m_axi_rvalid;
                m_axi_rready = s_rready[i];
            end
        end
    end

    assign s_rdata   = m_axi_rdata;
    assign s_rresp   = m_axi_rresp;
    assign s_rlast   = m_axi_rlast;

    assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // ------------------------------------------------------------------
    // Outstanding counters and error flags
    // ------------------------------------------------------------------

    always_comb begin
        cnt_inc   = '0;
        cnt_dec   = '0;
        underflow = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_inc[i]   = capture && (winner == PTR_W'(i));
            cnt_dec[i]   = r_last_hs && (m_axi_rid == ID_WIDTH'(i));
            underflow[i] = cnt_dec[i] && (cnt[i] == 4'd0);
        end
    end

    // Simultaneous inc/dec leaves the count alone; a dec at zero saturates
    // and is reported through err_flags[1] instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + 4'd1;
                end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != 4'd0)) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 2'b00;
        end else begin
            if (m_axi_rvalid && !rid_hit) begin
                err_q[0] <= 1'b1;
            end
            if (|underflow) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err_flags = err_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_outstanding
        assign outstanding[g*4 +: 4] = cnt[g];
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Purpose : randomized + directed stimulus for axi_rd_arbiter with a scoreboard.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).

module tb_axi_rd_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 4;
    localparam int MAXO = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0]   s_araddr;
    logic [N*8-1:0]    s_arlen;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              m_axi_arvalid, m_axi_arready;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [IW-1:0]     m_axi_arid;
    logic              m_axi_rvalid, m_axi_rready;
    logic [DW-1:0]     m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic [IW-1:0]     m_axi_rid;
    logic [N*4-1:0]    outstanding;
    logic [1:0]        err_flags;

    axi_rd_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
        .outstanding(outstanding), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } ar_t;

    typedef struct packed {
        logic [IW-1:0] rid;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];
    int  seen_arid[$];

    // Reference model state: what the arbiter should hold after the last edge.
    bit            m_full;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;
    int            m_id;
    int            m_ptr;
    int            m_cnt[N];
    logic [1:0]    m_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_addr = '0;
        m_len  = '0;
        m_id   = 0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_err  = 2'b00;
        exp_ar.delete();
        exp_r.delete();
    endtask

    task automatic model_step();
        bit         arv[N];
        int         win;
        int         dec;
        int         rid;
        logic [N-1:0] exp_ardy;
        logic [N-1:0] exp_rv;
        logic       exp_mr;
        ar_t        a;
        r_t         r;

        // registered state seen by the DUT since the last edge
        chk("m_axi_arvalid", m_axi_arvalid, m_full);
        if (m_full) begin
            chk("m_axi_araddr", m_axi_araddr, m_addr);
            chk("m_axi_arlen", m_axi_arlen, m_len);
            chk("m_axi_arid", m_axi_arid, m_id);
        end
        for (int i = 0; i < N; i++) chk("outstanding", outstanding[i*4 +: 4], m_cnt[i]);
        chk("err_flags", err_flags, m_err);

        // AR: a free holding slot goes to the first willing requester
        // (under its limit) found by walking round from the pointer.
        for (int i = 0; i < N; i++) arv[i] = s_arvalid[i];
        win = -1;
        if (!m_full) begin
            for (int k = 0; k < N && win < 0; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (arv[j] && m_cnt[j] < MAXO) win = j;
            end
        end
        exp_ardy = '0;
        for (int i = 0; i < N; i++) if (i == win) exp_ardy[i] = 1'b1;
        chk("s_arready", s_arready, exp_ardy);

        // R routing
        rid    = int'(m_axi_rid);
        exp_rv = '0;
        exp_mr = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == rid) begin
                exp_rv[i] = m_axi_rvalid;
                exp_mr    = s_rready[i];
            end
        end
        chk("m_axi_rready", m_axi_rready, exp_mr);
        chk("s_rvalid", s_rvalid, exp_rv);

        // advance model to the coming edge
        dec = -1;
        if (m_axi_rvalid && rid >= N) m_err[0] = 1'b1;
        if (m_axi_rvalid && rid < N && exp_mr) begin
            r.rid  = m_axi_rid;
            r.data = m_axi_rdata;
            r.resp = m_axi_rresp;
            r.last = m_axi_rlast;
            exp_r.push_back(r);
            if (m_axi_rlast) dec = rid;
        end
        if (m_full) begin
            if (m_axi_arready) m_full = 1'b0;
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_addr = s_araddr[win*AW +: AW];
            m_len  = s_arlen[win*8 +: 8];
            m_id   = win;
            a.addr = m_addr;
            a.len  = m_len;
            a.id   = IW'(win);
            exp_ar.push_back(a);
            m_ptr  = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (i == dec && m_cnt[i] == 0) m_err[1] = 1'b1;
            if (i == win && i != dec) m_cnt[i] = m_cnt[i] + 1;
            else if (i == dec && i != win && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    // model: predicts and queues at each falling edge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // monitor: pops and compares whenever the DUT completes a handshake
    initial begin
        ar_t a;
        r_t  r;
        int  idx;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (m_axi_arvalid && m_axi_arready) begin
                    chk("ar_expected", exp_ar.size() != 0, 1'b1);
                    if (exp_ar.size() != 0) begin
                        a = exp_ar.pop_front();
                        chk("sb_araddr", m_axi_araddr, a.addr);
                        chk("sb_arlen", m_axi_arlen, a.len);
                        chk("sb_arid", m_axi_arid, a.id);
                    end
                    seen_arid.push_back(int'(m_axi_arid));
                end
                if (|(s_rvalid & s_rready)) begin
                    idx = -1;
                    for (int i = 0; i < N; i++) if (s_rvalid[i] && s_rready[i] && idx < 0) idx = i;
                    chk("r_expected", exp_r.size() != 0, 1'b1);
                    if (exp_r.size() != 0) begin
                        r = exp_r.pop_front();
                        chk("sb_r_dest", idx, r.rid);
                        chk("sb_rdata", s_rdata, r.data);
                        chk("sb_rresp", s_rresp, r.resp);
                        chk("sb_rlast", s_rlast, r.last);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_arvalid     = '0;
        s_araddr      = '0;
        s_arlen       = '0;
        s_rready      = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit got;

        rst = 1'b1;
        idle_inputs();
        cyc(2);
        chk("reset_arvalid", m_axi_arvalid, 1'b0);
        chk("reset_araddr", m_axi_araddr, 0);
        chk("reset_arlen", m_axi_arlen, 0);
        chk("reset_arid", m_axi_arid, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_err", err_flags, 2'b00);
        chk("reset_arready", s_arready, 2'b00);
        rst = 1'b0;
        cyc();

        // single request
        m_axi_arready        = 1'b1;
        s_arvalid            = 2'b01;
        s_araddr[0 +: AW]    = 32'h1000;
        s_arlen[0 +: 8]      = 8'd15;
        #1;
        chk("single_arready_c0", s_arready, 2'b01);
        cyc();
        s_arvalid = '0;
        chk("single_arvalid_c1", m_axi_arvalid, 1'b1);
        chk("single_arid", m_axi_arid, 0);
        chk("single_araddr", m_axi_araddr, 32'h1000);
        chk("single_arlen", m_axi_arlen, 8'd15);
        chk("single_out_1", outstanding[3:0], 4'd1);
        cyc();
        for (int b = 0; b < 16; b++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rid    = '0;
            m_axi_rlast  = (b == 15);
            m_axi_rdata  = $urandom;
            s_rready     = 2'b01;
            if (b == 15) chk("single_out_before_last", outstanding[3:0], 4'd1);
            cyc();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        chk("single_out_0", outstanding[3:0], 4'd0);

        // round robin
        do_reset();
        seen_arid.delete();
        m_axi_arready      = 1'b1;
        s_araddr[0 +: AW]  = 32'hA000;
        s_araddr[AW +: AW] = 32'hB000;
        s_arvalid          = 2'b11;
        for (int c = 0; c < 8; c++) begin
            chk("rr_arvalid_pattern", m_axi_arvalid, (c % 2) == 1);
            cyc();
        end
        s_arvalid = '0;
        chk("rr_count", seen_arid.size(), 4);
        if (seen_arid.size() == 4) begin
            chk("rr_grant0", seen_arid[0], 0);
            chk("rr_grant1", seen_arid[1], 1);
            chk("rr_grant2", seen_arid[2], 0);
            chk("rr_grant3", seen_arid[3], 1);
        end

        // outstanding limit
        do_reset();
        m_axi_arready = 1'b1;
        s_arvalid     = 2'b01;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (s_arready[0]) n++;
            cyc();
        end
        chk("limit_grants", n, MAXO);
        chk("limit_out", outstanding[3:0], MAXO);
        chk("limit_arready_low", s_arready[0], 1'b0);
        m_axi_rvalid = 1'b1;
        m_axi_rid    = '0;
        m_axi_rlast  = 1'b1;
        s_rready     = 2'b01;
        cyc();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (s_arready[0]) got = 1'b1;
            cyc();
        end
        chk("limit_release", got, 1'b1);
        s_arvalid = '0;
        cyc(2);

        // backpressure
        do_reset();
        m_axi_arready      = 1'b0;
        s_arvalid          = 2'b10;
        s_araddr[AW +: AW] = 32'hABCD0;
        s_arlen[8 +: 8]    = 8'd7;
        cyc();
        s_arvalid          = 2'b11;
        s_araddr[0 +: AW]  = 32'h5555;
        for (int c = 0; c < 5; c++) begin
            chk("stall_arvalid", m_axi_arvalid, 1'b1);
            chk("stall_araddr", m_axi_araddr, 32'hABCD0);
            chk("stall_arlen", m_axi_arlen, 8'd7);
            chk("stall_arid", m_axi_arid, 1);
            chk("stall_arready", s_arready, 2'b00);
            cyc();
        end
        s_arvalid     = '0;
        m_axi_arready = 1'b1;
        cyc(2);

        // R routing and errors
        do_reset();
        s_rready     = 2'b10;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        m_axi_rid = IW'(1); m_axi_rdata = 32'h11; #1; chk("route_rid1_a", m_axi_rready, 1'b1); cyc();
        m_axi_rid = IW'(0); m_axi_rdata = 32'h22; #1; chk("route_rid0", m_axi_rready, 1'b0); cyc();
        m_axi_rid = IW'(1); m_axi_rdata = 32'h33; #1; chk("route_rid1_b", m_axi_rready, 1'b1); cyc();
        chk("route_err_clean", err_flags, 2'b00);
        m_axi_rid = IW'(5);
        #1;
        chk("drop_rready", m_axi_rready, 1'b1);
        chk("drop_rvalid", s_rvalid, 2'b00);
        cyc();
        m_axi_rvalid = 1'b0;
        chk("drop_err", err_flags, 2'b01);
        m_axi_rvalid = 1'b1;
        m_axi_rid    = IW'(1);
        m_axi_rlast  = 1'b1;
        cyc();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        chk("underflow_err", err_flags, 2'b11);
        chk("underflow_out", outstanding, 8'h00);

        // async reset mid-burst
        do_reset();
        m_axi_arready = 1'b1;
        s_arvalid     = 2'b10;
        cyc(6);
        s_arvalid     = 2'b01;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rid     = IW'(5);
        cyc();
        s_arvalid     = '0;
        m_axi_rvalid  = 1'b0;
        chk("pre_rst_out", outstanding, 8'h31);
        chk("pre_rst_arvalid", m_axi_arvalid, 1'b1);
        chk("pre_rst_err", err_flags, 2'b01);
        #1 rst = 1'b1;
        #1;
        chk("arst_arvalid", m_axi_arvalid, 1'b0);
        chk("arst_out", outstanding, 8'h00);
        chk("arst_err", err_flags, 2'b00);
        cyc();
        rst = 1'b0;

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                s_arvalid[i]          = ($urandom_range(0, 2) != 0);
                s_araddr[i*AW +: AW]  = $urandom;
                s_arlen[i*8 +: 8]     = 8'($urandom);
                s_rready[i]           = ($urandom_range(0, 3) != 0);
            end
            m_axi_arready = ($urandom_range(0, 3) != 0);
            m_axi_rvalid  = ($urandom_range(0, 1) != 0);
            m_axi_rid     = ($urandom_range(0, 15) == 0) ? IW'(5) : IW'($urandom_range(0, N - 1));
            m_axi_rlast   = ($urandom_range(0, 3) == 0);
            m_axi_rdata   = $urandom;
            m_axi_rresp   = 2'($urandom);
            cyc();
        end
        idle_inputs();
        m_axi_arready = 1'b1;
        cyc(4);
        chk("drain_ar_queue", exp_ar.size(), 0);
        chk("drain_r_queue", exp_r.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
